fwd_hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline's combinational bypass logic.
- Generates per-source forwarding selects for the DX stage, plus decode-stage stall/bubble control.
- Adds a scoreboard and an in-order pending-destination FIFO, so the variable-latency mult/div unit can have up to MD_DEPTH writes outstanding.
- Sits beside the FD/DX/XM/MW latches and drives operand muxes, PC/FD hold and DX nop insertion.

---
 rtl/fwd_hazard_scoreboard.sv | 148 ++++++++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_scoreboard.sv
// Operand forwarding selects and decode-stage stall control, with a busy-register
// scoreboard and an in-order FIFO tracking outstanding mult/div destinations.
module fwd_hazard_scoreboard #(
    parameter int NREGS    = 32,
    parameter int RW       = 5,
    parameter int NSRC     = 3,
    parameter int MD_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NSRC*RW-1:0]   d_src_addr,
    input  logic [NSRC-1:0]      d_src_used,
    input  logic [RW-1:0]        d_rd,
    input  logic                 d_we,
    input  logic                 d_is_md,
    input  logic [NSRC*RW-1:0]   dx_src_addr,
    input  logic [NSRC-1:0]      dx_src_used,
    input  logic [RW-1:0]        dx_rd,
    input  logic                 dx_we,
    input  logic                 dx_is_load,
    input  logic                 md_start,
    input  logic [RW-1:0]        xm_rd,
    input  logic                 xm_we,
    input  logic [RW-1:0]        mw_rd,
    input  logic                 mw_we,
    input  logic                 md_done,
    output logic                 stall_fd,
    output logic                 bubble_dx,
    output logic [NSRC*2-1:0]    fwd_sel,
    output logic [RW-1:0]        md_wb_rd,
    output logic                 md_pending,
    output logic                 md_full,
    output logic [1:0]           err_flags,
    output logic [CNT_W-1:0]     stall_count
);

    localparam int PW    = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
    localparam int CW    = $clog2(MD_DEPTH + 1);
    localparam int NADDR = 1 << RW;

    logic [NREGS-1:0] busy;
    logic [NADDR-1:0] busy_ext;
    logic [NADDR-1:0] busy_next;
    logic [RW-1:0]    fifo_mem [MD_DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic             overflow;
    logic             underflow;
    logic             load_use;
    logic             raw_hit;
    logic             waw_hit;
    logic             struct_hit;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(MD_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Widened to the full address space so any RW-bit address indexes safely.
    assign busy_ext = NADDR'(busy);

    assign md_pending = (count != '0);
    assign md_full    = (count == CW'(MD_DEPTH));
    assign md_wb_rd   = md_pending ? fifo_mem[head] : '0;

    assign push      = md_start && (!md_full || md_done);
    assign pop       = md_done && md_pending;
    assign overflow  = md_start && md_full && !md_done;
    assign underflow = md_done && !md_pending;

    always_comb begin
        load_use = 1'b0;
        raw_hit  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (d_src_used[i] && d_src_addr[i*RW +: RW] != '0) begin
                if (dx_is_load && dx_we && d_src_addr[i*RW +: RW] == dx_rd)
                    load_use = 1'b1;
                if (busy_ext[d_src_addr[i*RW +: RW]])
                    raw_hit = 1'b1;
            end
        end
        waw_hit    = d_we && (d_rd != '0) && busy_ext[d_rd];
        struct_hit = d_is_md && md_full && !md_done;
    end

    assign stall_fd  = load_use || raw_hit || waw_hit || struct_hit;
    assign bubble_dx = stall_fd;

    always_comb begin
        logic [RW-1:0] src;
        src     = '0;
        fwd_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            src = dx_src_addr[i*RW +: RW];
            fwd_sel[i*2 +: 2] = 2'b10;
            if (dx_src_used[i] && src != '0) begin
                if (xm_we && xm_rd == src)
                    fwd_sel[i*2 +: 2] = 2'b00;
                else if (mw_we && mw_rd == src)
                    fwd_sel[i*2 +: 2] = 2'b01;
                else if (md_done && md_pending && md_wb_rd == src)
                    fwd_sel[i*2 +: 2] = 2'b11;
            end
        end
    end

    // Clear on retire first so a same-register launch in the same cycle wins.
    always_comb begin
        busy_next = busy_ext;
        if (pop)
            busy_next[md_wb_rd] = 1'b0;
        if (push && dx_rd != '0)
            busy_next[dx_rd] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[tail] <= dx_rd;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy        <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            err_flags   <= '0;
            stall_count <= '0;
        end else begin
            busy <= busy_next[NREGS-1:0];
            if (push)
                tail <= wrap_inc(tail);
            if (pop)
                head <= wrap_inc(head);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            err_flags <= err_flags | {underflow, overflow};
            if (stall_fd && stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed-vector bench for fwd_hazard_scoreboard with a two-deep mult/div FIFO
// and a narrow stall counter so saturation is reachable.
module tb_fwd_hazard_scoreboard;

    localparam int RW    = 5;
    localparam int NSRC  = 3;
    localparam int CNT_W = 4;

    logic                clock = 1'b0;
    logic                reset;
    logic [NSRC*RW-1:0]  d_src_addr;
    logic [NSRC-1:0]     d_src_used;
    logic [RW-1:0]       d_rd;
    logic                d_we;
    logic                d_is_md;
    logic [NSRC*RW-1:0]  dx_src_addr;
    logic [NSRC-1:0]     dx_src_used;
    logic [RW-1:0]       dx_rd;
    logic                dx_we;
    logic                dx_is_load;
    logic                md_start;
    logic [RW-1:0]       xm_rd;
    logic                xm_we;
    logic [RW-1:0]       mw_rd;
    logic                mw_we;
    logic                md_done;
    logic                stall_fd;
    logic                bubble_dx;
    logic [NSRC*2-1:0]   fwd_sel;
    logic [RW-1:0]       md_wb_rd;
    logic                md_pending;
    logic                md_full;
    logic [1:0]          err_flags;
    logic [CNT_W-1:0]    stall_count;

    int vectorCount     = 0;
    int miscompareCount = 0;

    always #5 clock = ~clock;

    fwd_hazard_scoreboard #(
        .NREGS(32), .RW(RW), .NSRC(NSRC), .MD_DEPTH(2), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .d_src_addr(d_src_addr), .d_src_used(d_src_used), .d_rd(d_rd),
        .d_we(d_we), .d_is_md(d_is_md),
        .dx_src_addr(dx_src_addr), .dx_src_used(dx_src_used), .dx_rd(dx_rd),
        .dx_we(dx_we), .dx_is_load(dx_is_load), .md_start(md_start),
        .xm_rd(xm_rd), .xm_we(xm_we), .mw_rd(mw_rd), .mw_we(mw_we),
        .md_done(md_done),
        .stall_fd(stall_fd), .bubble_dx(bubble_dx), .fwd_sel(fwd_sel),
        .md_wb_rd(md_wb_rd), .md_pending(md_pending), .md_full(md_full),
        .err_flags(err_flags), .stall_count(stall_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        d_src_addr  = '0; d_src_used  = '0; d_rd  = '0; d_we  = 0; d_is_md = 0;
        dx_src_addr = '0; dx_src_used = '0; dx_rd = '0; dx_we = 0; dx_is_load = 0;
        md_start = 0; xm_rd = '0; xm_we = 0; mw_rd = '0; mw_we = 0; md_done = 0;
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1;
        clearInputs();
        applyStimulus();
        applyStimulus();
        reset = 0;
        #1;
        checkOutput("reset_fwd", fwd_sel, 6'b101010);
        checkOutput("reset_stall", stall_fd, 0);
        checkOutput("reset_bubble", bubble_dx, 0);
        checkOutput("reset_pending", md_pending, 0);
        checkOutput("reset_full", md_full, 0);
        checkOutput("reset_wb_rd", md_wb_rd, 0);
        checkOutput("reset_err", err_flags, 0);
        checkOutput("reset_count", stall_count, 0);

        // Forwarding priority and r0 exclusion
        dx_src_addr = {5'd0, 5'd0, 5'd5}; dx_src_used = 3'b001;
        xm_we = 1; xm_rd = 5; mw_we = 1; mw_rd = 5;
        #1 checkOutput("fwd_xm_wins", fwd_sel, 6'b101000);
        xm_we = 0;
        #1 checkOutput("fwd_mw", fwd_sel, 6'b101001);
        dx_src_addr = {5'd0, 5'd0, 5'd0}; xm_rd = 0; xm_we = 1;
        #1 checkOutput("fwd_r0", fwd_sel, 6'b101010);
        dx_src_addr = {5'd6, 5'd0, 5'd0}; dx_src_used = 3'b100; xm_we = 0; mw_rd = 6;
        #1 checkOutput("fwd_lane2_mw", fwd_sel, 6'b011010);
        dx_src_used = 3'b000;
        #1 checkOutput("fwd_unused", fwd_sel, 6'b101010);
        clearInputs();

        // Load-use: unused lane never stalls, used lane stalls one cycle
        dx_is_load = 1; dx_we = 1; dx_rd = 7;
        d_src_addr = {5'd0, 5'd7, 5'd0}; d_src_used = 3'b001;
        #1 checkOutput("lu_unused_lane", stall_fd, 0);
        d_src_used = 3'b010;
        #1 checkOutput("lu_stall", stall_fd, 1);
        checkOutput("lu_bubble", bubble_dx, 1);
        applyStimulus();
        dx_is_load = 0; dx_we = 0; dx_rd = 0;
        #1 checkOutput("lu_release", stall_fd, 0);
        checkOutput("lu_bubble_off", bubble_dx, 0);
        checkOutput("lu_count", stall_count, 1);
        clearInputs();
        applyStimulus();
        checkOutput("lu_count_hold", stall_count, 1);

        // Mult/div to r9 with a waiting consumer
        md_start = 1; dx_rd = 9;
        applyStimulus();
        md_start = 0; dx_rd = 0;
        d_src_addr = {5'd0, 5'd0, 5'd9}; d_src_used = 3'b001;
        #1 checkOutput("md_pending", md_pending, 1);
        checkOutput("md_wb_rd9", md_wb_rd, 9);
        checkOutput("md_not_full", md_full, 0);
        checkOutput("md_raw_stall1", stall_fd, 1);
        applyStimulus();
        checkOutput("md_raw_stall2", stall_fd, 1);
        applyStimulus();
        md_done = 1; dx_src_addr = {5'd0, 5'd0, 5'd9}; dx_src_used = 3'b001;
        #1 checkOutput("md_done_stall", stall_fd, 1);
        checkOutput("md_done_fwd", fwd_sel, 6'b101011);
        checkOutput("md_done_wb_rd", md_wb_rd, 9);
        applyStimulus();
        md_done = 0;
        #1 checkOutput("md_release", stall_fd, 0);
        checkOutput("md_empty", md_pending, 0);
        checkOutput("md_fwd_after", fwd_sel, 6'b101010);
        checkOutput("md_count", stall_count, 4);
        clearInputs();

        // Fill the two-deep FIFO with r3, r4
        md_start = 1; dx_rd = 3;
        applyStimulus();
        dx_rd = 4;
        applyStimulus();
        md_start = 0; dx_rd = 0;
        #1 checkOutput("full_flag", md_full, 1);
        checkOutput("full_wb_rd", md_wb_rd, 3);
        d_is_md = 1;
        #1 checkOutput("struct_stall", stall_fd, 1);
        d_is_md = 0; d_we = 1; d_rd = 4;
        #1 checkOutput("waw_stall", stall_fd, 1);
        d_we = 0; d_rd = 0; d_is_md = 1; md_done = 1; md_start = 1; dx_rd = 5;
        #1 checkOutput("struct_release", stall_fd, 0);
        checkOutput("popush_wb_rd", md_wb_rd, 3);
        applyStimulus();
        clearInputs();
        #1 checkOutput("popush_full", md_full, 1);
        checkOutput("popush_wb_rd4", md_wb_rd, 4);
        checkOutput("popush_err", err_flags, 0);
        d_src_addr = {5'd0, 5'd0, 5'd3}; d_src_used = 3'b001;
        #1 checkOutput("busy3_cleared", stall_fd, 0);
        d_src_addr = {5'd0, 5'd0, 5'd5};
        #1 checkOutput("busy5_set", stall_fd, 1);
        clearInputs();

        // Overflow: push r6 while full without a retire
        md_start = 1; dx_rd = 6;
        applyStimulus();
        clearInputs();
        #1 checkOutput("ovf_err", err_flags, 2'b01);
        checkOutput("ovf_wb_rd", md_wb_rd, 4);
        checkOutput("ovf_full", md_full, 1);
        d_src_addr = {5'd0, 5'd0, 5'd6}; d_src_used = 3'b001;
        #1 checkOutput("ovf_no_busy6", stall_fd, 0);
        clearInputs();
        md_done = 1;
        applyStimulus();
        md_done = 0;
        #1 checkOutput("ovf_next_wb_rd", md_wb_rd, 5);
        checkOutput("ovf_pending", md_pending, 1);
        checkOutput("ovf_not_full", md_full, 0);

        // Reset with two entries pending (r5, r4)
        md_start = 1; dx_rd = 4;
        applyStimulus();
        clearInputs();
        d_src_addr = {5'd0, 5'd0, 5'd4}; d_src_used = 3'b001;
        #1 checkOutput("pre_reset_stall", stall_fd, 1);
        reset = 1;
        applyStimulus();
        reset = 0;
        #1 checkOutput("rst_pending", md_pending, 0);
        checkOutput("rst_full", md_full, 0);
        checkOutput("rst_err", err_flags, 0);
        checkOutput("rst_count", stall_count, 0);
        checkOutput("rst_wb_rd", md_wb_rd, 0);
        checkOutput("rst_no_stall", stall_fd, 0);
        clearInputs();

        // Underflow: md_done with nothing pending
        md_done = 1; dx_src_addr = {5'd0, 5'd0, 5'd9}; dx_src_used = 3'b001;
        #1 checkOutput("udf_fwd", fwd_sel, 6'b101010);
        applyStimulus();
        clearInputs();
        #1 checkOutput("udf_err", err_flags, 2'b10);
        checkOutput("udf_pending", md_pending, 0);

        // Saturation of the stall counter
        dx_is_load = 1; dx_we = 1; dx_rd = 7;
        d_src_addr = {5'd0, 5'd7, 5'd0}; d_src_used = 3'b010;
        repeat (20) applyStimulus();
        checkOutput("sat_count", stall_count, 15);
        clearInputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
